// File: rtl/ripple_mon_pkg.sv
// Shared types and default sizes for the ripple-counter monitor.
// Holds the snapshot handshake state encoding used by ripple_count_monitor.
package ripple_mon_pkg;

  localparam int CNT_W_DEF  = 4;
  localparam int WRAP_W_DEF = 8;

  typedef enum logic [0:0] {
    SNAP_IDLE = 1'b0,
    SNAP_HOLD = 1'b1
  } snap_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a multi-bit asynchronous bus.
// Bits may resolve on different edges; the caller filters for a stable value.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_r;
  logic [W-1:0] s2_r;

  // Synchronizer chain with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_r <= '0;
      s2_r <= '0;
    end else begin
      s1_r <= d;
      s2_r <= s1_r;
    end
  end

  assign q = s2_r;

endmodule

// File: rtl/ripple_count_monitor.sv
// Monitors an asynchronous ripple up-counter: filters and synchronizes it,
// counts wraps, flags skipped values and matches, and offers a held snapshot.
module ripple_count_monitor
  import ripple_mon_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WRAP_W = WRAP_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [CNT_W-1:0]        q_in,
  input  logic [CNT_W-1:0]        match_val,
  input  logic                    clr,
  input  logic                    snap_req,
  input  logic                    snap_ack,
  output logic [CNT_W-1:0]        q_stable,
  output logic                    wrap_pulse,
  output logic [WRAP_W-1:0]       wrap_cnt,
  output logic                    match_hit,
  output logic                    match_sticky,
  output logic                    skip_err,
  output logic                    snap_valid,
  output logic [WRAP_W+CNT_W-1:0] snap_data
);

  localparam logic [CNT_W-1:0]  CNT_ONES = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;
  localparam logic [WRAP_W-1:0] WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]        s2_s;
  logic [CNT_W-1:0]        s3_r;
  logic [CNT_W-1:0]        q_stable_r;
  logic [CNT_W-1:0]        old_r;
  logic                    upd_s;
  logic                    upd_r;
  logic                    chk_r;
  logic                    first_r;
  logic                    wrap_ev_s;
  logic                    skip_ev_s;
  logic                    match_ev_s;
  logic [WRAP_W-1:0]       wrap_base_s;
  logic [WRAP_W-1:0]       wrap_nx_s;
  logic [WRAP_W-1:0]       wrap_cnt_r;
  logic                    wrap_pulse_r;
  logic                    match_hit_r;
  logic                    match_sticky_r;
  logic                    skip_err_r;
  snap_state_e             snap_state_r;
  snap_state_e             snap_nx_s;
  logic [WRAP_W+CNT_W-1:0] snap_data_r;
  logic [WRAP_W+CNT_W-1:0] snap_data_nx_s;
  logic                    snap_valid_r;

  sync_2ff #(.W(CNT_W)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (q_in),
    .q       (s2_s)
  );

  // Update qualification and event decode one cycle after the update lands.
  always_comb begin
    upd_s      = (s2_s == s3_r) && (s2_s != q_stable_r);
    wrap_ev_s  = upd_r && chk_r && (old_r == CNT_ONES) && (q_stable_r == '0);
    skip_ev_s  = upd_r && chk_r && (q_stable_r != (old_r + CNT_ONE));
    match_ev_s = upd_r && (q_stable_r == match_val);
  end

  // Saturating wrap count; clear applies before a coincident wrap.
  always_comb begin
    wrap_base_s = clr ? '0 : wrap_cnt_r;
    if (wrap_ev_s && (wrap_base_s != WRAP_MAX)) begin
      wrap_nx_s = wrap_base_s + WRAP_ONE;
    end else begin
      wrap_nx_s = wrap_base_s;
    end
  end

  // Snapshot handshake next-state and capture.
  always_comb begin
    snap_nx_s      = snap_state_r;
    snap_data_nx_s = snap_data_r;
    case (snap_state_r)
      SNAP_IDLE: begin
        if (snap_req) begin
          snap_nx_s      = SNAP_HOLD;
          snap_data_nx_s = {wrap_cnt_r, q_stable_r};
        end else begin
          snap_nx_s = SNAP_IDLE;
        end
      end
      SNAP_HOLD: begin
        if (snap_ack) begin
          snap_nx_s = SNAP_IDLE;
        end else begin
          snap_nx_s = SNAP_HOLD;
        end
      end
      default: snap_nx_s = SNAP_IDLE;
    endcase
  end

  // Filter, event and sticky registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s3_r           <= '0;
      q_stable_r     <= '0;
      old_r          <= '0;
      upd_r          <= 1'b0;
      chk_r          <= 1'b0;
      first_r        <= 1'b1;
      wrap_cnt_r     <= '0;
      wrap_pulse_r   <= 1'b0;
      match_hit_r    <= 1'b0;
      match_sticky_r <= 1'b0;
      skip_err_r     <= 1'b0;
    end else begin
      s3_r  <= s2_s;
      upd_r <= upd_s;
      if (upd_s) begin
        q_stable_r <= s2_s;
        old_r      <= q_stable_r;
        chk_r      <= ~first_r;
        first_r    <= 1'b0;
      end
      wrap_cnt_r     <= wrap_nx_s;
      wrap_pulse_r   <= wrap_ev_s;
      match_hit_r    <= match_ev_s;
      match_sticky_r <= (match_sticky_r & ~clr) | match_ev_s;
      skip_err_r     <= (skip_err_r & ~clr) | skip_ev_s;
    end
  end

  // Snapshot state and held data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      snap_state_r <= SNAP_IDLE;
      snap_data_r  <= '0;
      snap_valid_r <= 1'b0;
    end else begin
      snap_state_r <= snap_nx_s;
      snap_data_r  <= snap_data_nx_s;
      snap_valid_r <= (snap_nx_s == SNAP_HOLD);
    end
  end

  assign q_stable     = q_stable_r;
  assign wrap_pulse   = wrap_pulse_r;
  assign wrap_cnt     = wrap_cnt_r;
  assign match_hit    = match_hit_r;
  assign match_sticky = match_sticky_r;
  assign skip_err     = skip_err_r;
  assign snap_valid   = snap_valid_r;
  assign snap_data    = snap_data_r;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed self-checking bench for ripple_count_monitor (default widths).
// Inputs change just after the falling edge; outputs are sampled there too.
module tb_ripple_count_monitor;

  logic        clk;
  logic        reset_n;
  logic [3:0]  q_in;
  logic [3:0]  match_val;
  logic        clr;
  logic        snap_req;
  logic        snap_ack;
  logic [3:0]  q_stable;
  logic        wrap_pulse;
  logic [7:0]  wrap_cnt;
  logic        match_hit;
  logic        match_sticky;
  logic        skip_err;
  logic        snap_valid;
  logic [11:0] snap_data;

  int n_checks;
  int n_fails;
  int upd_cnt;
  int wrap_seen;
  int match_seen;
  int watch_hits;
  logic [3:0] watch_val;
  logic [3:0] prev_q;

  ripple_count_monitor dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .q_in         (q_in),
    .match_val    (match_val),
    .clr          (clr),
    .snap_req     (snap_req),
    .snap_ack     (snap_ack),
    .q_stable     (q_stable),
    .wrap_pulse   (wrap_pulse),
    .wrap_cnt     (wrap_cnt),
    .match_hit    (match_hit),
    .match_sticky (match_sticky),
    .skip_err     (skip_err),
    .snap_valid   (snap_valid),
    .snap_data    (snap_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock, then tally observed activity at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (q_stable != prev_q) upd_cnt++;
    prev_q = q_stable;
    if (wrap_pulse) wrap_seen++;
    if (match_hit) match_seen++;
    if (q_stable == watch_val) watch_hits++;
  endtask

  task automatic hold(input logic [3:0] v, input int n);
    q_in = v;
    repeat (n) step();
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fails = 0;
    upd_cnt = 0; wrap_seen = 0; match_seen = 0; watch_hits = 0;
    watch_val = 4'h0; prev_q = 4'h0;
    reset_n = 1'b0; q_in = 4'h0; match_val = 4'h0;
    clr = 1'b0; snap_req = 1'b0; snap_ack = 1'b0;
    step(); step();
    check_val("rst_q_stable", 32'(q_stable), 32'h0);
    check_val("rst_wrap_cnt", 32'(wrap_cnt), 32'h0);
    check_val("rst_snap_valid", 32'(snap_valid), 32'h0);
    reset_n = 1'b1;
    step();

    // Full count 0..F..0 with a latency probe on the first value.
    upd_cnt = 0; wrap_seen = 0;
    q_in = 4'h1;
    repeat (3) step();
    check_val("lat_before", 32'(q_stable), 32'h0);
    step();
    check_val("lat_after", 32'(q_stable), 32'h1);
    repeat (2) step();
    for (int v = 2; v < 16; v++) hold(4'(v), 6);
    hold(4'h0, 6);
    repeat (2) step();
    check_val("cnt_updates", 32'(upd_cnt), 32'd16);
    check_val("cnt_wrap_pulses", 32'(wrap_seen), 32'd1);
    check_val("cnt_wrap_cnt", 32'(wrap_cnt), 32'd1);
    check_val("cnt_skip_err", 32'(skip_err), 32'h0);
    check_val("cnt_final_q", 32'(q_stable), 32'h0);

    // One-cycle glitch at 3 between 2 and 4.
    pulse_clr();
    check_val("clr_wrap_cnt", 32'(wrap_cnt), 32'h0);
    hold(4'h1, 6);
    hold(4'h2, 6);
    check_val("glitch_pre_skip", 32'(skip_err), 32'h0);
    watch_val = 4'h3; watch_hits = 0;
    hold(4'h3, 1);
    hold(4'h4, 6);
    check_val("glitch_no_3", 32'(watch_hits), 32'd0);
    check_val("glitch_q", 32'(q_stable), 32'h4);
    check_val("glitch_skip_err", 32'(skip_err), 32'h1);
    watch_val = 4'h0;

    // Match on 9: single pulse one cycle after q_stable shows 9.
    match_val = 4'h9;
    pulse_clr();
    check_val("clr_skip_err", 32'(skip_err), 32'h0);
    match_seen = 0;
    for (int v = 5; v < 9; v++) hold(4'(v), 6);
    q_in = 4'h9;
    repeat (4) step();
    check_val("match_q9", 32'(q_stable), 32'h9);
    check_val("match_not_yet", 32'(match_hit), 32'h0);
    step();
    check_val("match_hit", 32'(match_hit), 32'h1);
    check_val("match_sticky_set", 32'(match_sticky), 32'h1);
    step();
    check_val("match_hit_drop", 32'(match_hit), 32'h0);
    repeat (3) step();
    for (int v = 10; v < 13; v++) hold(4'(v), 6);
    check_val("match_count", 32'(match_seen), 32'd1);
    check_val("match_sticky_hold", 32'(match_sticky), 32'h1);
    check_val("match_no_skip", 32'(skip_err), 32'h0);
    pulse_clr();
    check_val("match_sticky_clr", 32'(match_sticky), 32'h0);

    // 256 wraps saturate the wrap counter.
    pulse_clr();
    wrap_seen = 0;
    for (int i = 0; i < 256; i++) begin
      hold(4'hF, 3);
      hold(4'h0, 3);
    end
    repeat (4) step();
    check_val("sat_wrap_cnt", 32'(wrap_cnt), 32'd255);
    check_val("sat_pulses", 32'(wrap_seen), 32'd256);
    hold(4'hF, 6);
    hold(4'h0, 6);
    check_val("sat_held", 32'(wrap_cnt), 32'd255);
    hold(4'hF, 6);
    q_in = 4'h0;
    repeat (4) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_val("clr_wrap_pulse", 32'(wrap_pulse), 32'h1);
    check_val("clr_wrap_one", 32'(wrap_cnt), 32'd1);
    check_val("clr_wrap_noskip", 32'(skip_err), 32'h0);

    // Snapshot capture, freeze and req+ack collision.
    hold(4'hF, 6);
    hold(4'h0, 6);
    hold(4'h5, 6);
    check_val("snap_pre_wrap", 32'(wrap_cnt), 32'd2);
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    check_val("snap_valid", 32'(snap_valid), 32'h1);
    check_val("snap_data", 32'(snap_data), 32'h025);
    hold(4'h6, 6);
    check_val("snap_q_moved", 32'(q_stable), 32'h6);
    check_val("snap_frozen", 32'(snap_data), 32'h025);
    snap_req = 1'b1; snap_ack = 1'b1;
    step();
    snap_req = 1'b0; snap_ack = 1'b0;
    check_val("snap_ack_drop", 32'(snap_valid), 32'h0);
    step();
    check_val("snap_no_recapture", 32'(snap_valid), 32'h0);
    check_val("snap_data_kept", 32'(snap_data), 32'h025);
    snap_ack = 1'b1;
    step();
    snap_ack = 1'b0;
    check_val("snap_idle_ack", 32'(snap_valid), 32'h0);
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    check_val("snap_recapture", 32'(snap_data), 32'h026);
    check_val("snap_valid_again", 32'(snap_valid), 32'h1);

    // Reset mid-HOLD clears everything; first update after it is not a skip.
    reset_n = 1'b0;
    step();
    check_val("mrst_q", 32'(q_stable), 32'h0);
    check_val("mrst_wrap_cnt", 32'(wrap_cnt), 32'h0);
    check_val("mrst_wrap_pulse", 32'(wrap_pulse), 32'h0);
    check_val("mrst_match_hit", 32'(match_hit), 32'h0);
    check_val("mrst_match_sticky", 32'(match_sticky), 32'h0);
    check_val("mrst_skip_err", 32'(skip_err), 32'h0);
    check_val("mrst_snap_valid", 32'(snap_valid), 32'h0);
    check_val("mrst_snap_data", 32'(snap_data), 32'h0);
    reset_n = 1'b1;
    hold(4'h7, 6);
    check_val("post_rst_q", 32'(q_stable), 32'h7);
    check_val("post_rst_noskip", 32'(skip_err), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
